// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic MAC array: accepts one tile of operand beats and
// drives lane i of the array edge with an i-cycle skew, framed by pe_clear and done.
module systolic_skew_feeder #(
    parameter int unsigned INPUT_WIDTH   = 8,
    parameter int unsigned LANES         = 4,
    parameter int unsigned VECTOR_LENGTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    input  logic [LANES*INPUT_WIDTH-1:0]   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [LANES*INPUT_WIDTH-1:0]   lane_data,
    output logic [LANES-1:0]               lane_valid,
    output logic                           pe_clear,
    output logic                           done
);

    localparam int unsigned BEAT_W  = $clog2(VECTOR_LENGTH + 1);
    localparam int unsigned DRAIN_W = $clog2(LANES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                pe_clear_q, pe_clear_d;
    logic                done_q, done_d;
    logic                accept_c;

    assign accept_c = in_valid & in_ready_q;

    // Next-state logic; the status outputs are registered decodes of the next state.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d    = S_FEED;
                beat_cnt_d = '0;
            end
            S_FEED: begin
                if (accept_c) begin
                    beat_cnt_d = BEAT_W'(beat_cnt_q + 1'b1);
                    if (beat_cnt_q == BEAT_W'(VECTOR_LENGTH - 1)) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(LANES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = DRAIN_W'(drain_cnt_q + 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_FEED);
        pe_clear_d = (state_d == S_CLEAR);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            pe_clear_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            pe_clear_q  <= pe_clear_d;
            done_q      <= done_d;
        end
    end

    assign busy     = busy_q;
    assign in_ready = in_ready_q;
    assign pe_clear = pe_clear_q;
    assign done     = done_q;

    // Lane i is an (i+1)-deep non-stalling shift register; empty slots carry zero data.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0][INPUT_WIDTH-1:0] data_q, data_d;
        logic [i:0]                  vld_q, vld_d;
        logic [INPUT_WIDTH-1:0]      head_c;

        assign head_c = accept_c ? in_data[i*INPUT_WIDTH +: INPUT_WIDTH] : '0;

        if (i == 0) begin : g_head
            always_comb begin
                data_d = head_c;
                vld_d  = accept_c;
            end
        end else begin : g_shift
            always_comb begin
                data_d = {data_q[i-1:0], head_c};
                vld_d  = {vld_q[i-1:0], accept_c};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign lane_data[i*INPUT_WIDTH +: INPUT_WIDTH] = data_q[i];
        assign lane_valid[i]                           = vld_q[i];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench: A/B feeder pair into a behavioural 4x4 MAC array, plus a 1x1 feeder.
module tb_systolic_skew_feeder;

    logic        clk;
    logic        rst_n;
    logic        start, in_valid;
    logic [31:0] in_data_a, in_data_b;
    logic        busy_a, in_ready_a, pe_clear_a, done_a;
    logic [31:0] lane_data_a;
    logic [3:0]  lane_valid_a;
    logic        busy_b, in_ready_b, pe_clear_b, done_b;
    logic [31:0] lane_data_b;
    logic [3:0]  lane_valid_b;
    logic        start_g, in_valid_g;
    logic [7:0]  in_data_g, lane_data_g;
    logic        busy_g, in_ready_g, pe_clear_g, done_g;
    logic [0:0]  lane_valid_g;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a),
        .in_data(in_data_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .lane_data(lane_data_a), .lane_valid(lane_valid_a),
        .pe_clear(pe_clear_a), .done(done_a)
    );

    systolic_skew_feeder u_feed_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b),
        .in_data(in_data_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .lane_data(lane_data_b), .lane_valid(lane_valid_b),
        .pe_clear(pe_clear_b), .done(done_b)
    );

    systolic_skew_feeder #(.INPUT_WIDTH(8), .LANES(1), .VECTOR_LENGTH(1)) u_deg (
        .clk(clk), .rst_n(rst_n), .start(start_g), .busy(busy_g),
        .in_data(in_data_g), .in_valid(in_valid_g), .in_ready(in_ready_g),
        .lane_data(lane_data_g), .lane_valid(lane_valid_g),
        .pe_clear(pe_clear_g), .done(done_g)
    );

    // Behavioural 4x4 output-stationary MAC array: A flows right, B flows down.
    logic [7:0] a_in_m [4][4], b_in_m [4][4], a_q_m [4][4], b_q_m [4][4];
    logic       av_in_m[4][4], bv_in_m[4][4], av_q_m[4][4], bv_q_m[4][4];
    int         acc_m  [4][4], cnt_m  [4][4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_in_m[i][0]  = lane_data_a[i*8 +: 8];
            av_in_m[i][0] = lane_valid_a[i];
            b_in_m[0][i]  = lane_data_b[i*8 +: 8];
            bv_in_m[0][i] = lane_valid_b[i];
            for (int j = 1; j < 4; j++) begin
                a_in_m[i][j]  = a_q_m[i][j-1];
                av_in_m[i][j] = av_q_m[i][j-1];
                b_in_m[j][i]  = b_q_m[j-1][i];
                bv_in_m[j][i] = bv_q_m[j-1][i];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_q_m[i][j] <= '0; b_q_m[i][j] <= '0;
                    av_q_m[i][j] <= 1'b0; bv_q_m[i][j] <= 1'b0;
                    acc_m[i][j] <= 0; cnt_m[i][j] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_q_m[i][j]  <= a_in_m[i][j];
                    b_q_m[i][j]  <= b_in_m[i][j];
                    av_q_m[i][j] <= av_in_m[i][j];
                    bv_q_m[i][j] <= bv_in_m[i][j];
                    if (pe_clear_a) begin
                        acc_m[i][j] <= 0;
                        cnt_m[i][j] <= 0;
                    end else if (av_in_m[i][j] && bv_in_m[i][j]) begin
                        acc_m[i][j] <= acc_m[i][j] + int'(a_in_m[i][j]) * int'(b_in_m[i][j]);
                        cnt_m[i][j] <= cnt_m[i][j] + 1;
                    end
                end
            end
        end
    end

    task automatic drive_slot(input int beat, input bit ones);
        in_valid  = (beat >= 0);
        in_data_b = 32'h0101_0101;
        for (int i = 0; i < 4; i++) begin
            if (beat < 0)  in_data_a[i*8 +: 8] = 8'hEE;
            else if (ones) in_data_a[i*8 +: 8] = 8'h01;
            else           in_data_a[i*8 +: 8] = 8'(16 * i + beat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data_a = '0; in_data_b = '0;
        start_g = 1'b0; in_valid_g = 1'b0; in_data_g = '0;
        #12;
        checks++;
        if ({busy_a, in_ready_a, pe_clear_a, done_a} !== 4'b0 || lane_data_a !== 32'h0 || lane_valid_a !== 4'h0) begin
            failures++;
            $display("FAIL reset_a busy/rdy/clr/done=%b lane_data=%h lane_valid=%h exp all 0",
                     {busy_a, in_ready_a, pe_clear_a, done_a}, lane_data_a, lane_valid_a);
        end
        checks++;
        if ({busy_g, in_ready_g, pe_clear_g, done_g} !== 4'b0 || lane_data_g !== 8'h0 || lane_valid_g !== 1'b0) begin
            failures++;
            $display("FAIL reset_g busy/rdy/clr/done=%b lane_data=%h lane_valid=%b exp all 0",
                     {busy_g, in_ready_g, pe_clear_g, done_g}, lane_data_g, lane_valid_g);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tile(input bit bubble, input bit ones, input bit noise, input string name);
        int slot[5];
        int slots;
        if (bubble) begin slot = '{0, 1, -1, 2, 3}; slots = 5; end
        else        begin slot = '{0, 1, 2, 3, -1}; slots = 4; end
        in_data_b = 32'h0101_0101;
        if (noise) begin
            in_valid = 1'b1; in_data_a = 32'hA5A5_A5A5;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if (in_ready_a !== 1'b0 || busy_a !== 1'b0 || lane_valid_a !== 4'h0) begin
                    failures++;
                    $display("FAIL %s idle_ignore rdy=%b busy=%b lane_valid=%h exp 0 0 0",
                             name, in_ready_a, busy_a, lane_valid_a);
                end
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (pe_clear_a !== 1'b1 || busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL %s clear_cycle clr/busy/rdy=%b%b%b exp 110", name, pe_clear_a, busy_a, in_ready_a);
        end
        @(negedge clk);
        checks++;
        if (pe_clear_a !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL %s feed_entry clr/rdy=%b%b exp 01", name, pe_clear_a, in_ready_a);
        end
        drive_slot(slot[0], ones);
        for (int t = 0; t <= slots + 8; t++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int s;
                bit ev;
                logic [7:0] ed;
                s = t - i; ev = 1'b0; ed = 8'h00;
                if (s >= 0 && s < slots) begin
                    if (slot[s] >= 0) begin
                        ev = 1'b1;
                        ed = ones ? 8'h01 : 8'(16 * i + slot[s]);
                    end
                end
                checks++;
                if (lane_valid_a[i] !== ev || lane_data_a[i*8 +: 8] !== ed) begin
                    failures++;
                    $display("FAIL %s lane%0d t=%0d got v=%b d=%h exp v=%b d=%h",
                             name, i, t, lane_valid_a[i], lane_data_a[i*8 +: 8], ev, ed);
                end
            end
            checks++;
            if (done_a !== (t == slots + 3) || busy_a !== (t <= slots + 3) || in_ready_a !== (t < slots - 1)) begin
                failures++;
                $display("FAIL %s ctrl t=%0d done/busy/rdy=%b%b%b exp %b%b%b", name, t, done_a, busy_a,
                         in_ready_a, (t == slots + 3), (t <= slots + 3), (t < slots - 1));
            end
            if (t + 1 < slots) drive_slot(slot[t+1], ones);
            else begin in_valid = noise; in_data_a = 32'hFFFF_FFFF; end
            start = noise && (t == 1 || t == slots + 1);
        end
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int exp_acc;
                exp_acc = ones ? 4 : 64 * i + 6;
                checks++;
                if (acc_m[i][j] !== exp_acc || cnt_m[i][j] !== 4) begin
                    failures++;
                    $display("FAIL %s acc[%0d][%0d] got %0d (n=%0d) exp %0d (n=4)",
                             name, i, j, acc_m[i][j], cnt_m[i][j], exp_acc);
                end
            end
        end
    endtask

    task automatic test_reset_mid_feed();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        drive_slot(0, 1'b0);
        @(negedge clk);
        drive_slot(1, 1'b0);
        @(negedge clk);
        checks++;
        if (lane_valid_a !== 4'b0011 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_feed_pre lane_valid=%h busy=%b exp 3 1", lane_valid_a, busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, in_ready_a, pe_clear_a, done_a} !== 4'b0 || lane_data_a !== 32'h0 || lane_valid_a !== 4'h0) begin
            failures++;
            $display("FAIL mid_feed_reset busy/rdy/clr/done=%b lane_data=%h lane_valid=%h exp all 0",
                     {busy_a, in_ready_a, pe_clear_a, done_a}, lane_data_a, lane_valid_a);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b0 || done_a !== 1'b0 || lane_valid_a !== 4'h0) begin
                failures++;
                $display("FAIL post_reset_idle busy/done=%b%b lane_valid=%h exp 00 0", busy_a, done_a, lane_valid_a);
            end
        end
        test_tile(1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    // Two 1x1 tiles, the second started in the first IDLE cycle after the first.
    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] val;
            val = (r == 0) ? 8'h5A : 8'hC3;
            start_g = 1'b1;
            @(negedge clk);
            start_g = 1'b0;
            checks++;
            if (pe_clear_g !== 1'b1 || busy_g !== 1'b1 || in_ready_g !== 1'b0) begin
                failures++;
                $display("FAIL deg%0d clear clr/busy/rdy=%b%b%b exp 110", r, pe_clear_g, busy_g, in_ready_g);
            end
            @(negedge clk);
            checks++;
            if (pe_clear_g !== 1'b0 || in_ready_g !== 1'b1) begin
                failures++;
                $display("FAIL deg%0d feed clr/rdy=%b%b exp 01", r, pe_clear_g, in_ready_g);
            end
            in_valid_g = 1'b1; in_data_g = val;
            @(negedge clk);
            in_valid_g = 1'b0;
            checks++;
            if (lane_valid_g !== 1'b1 || lane_data_g !== val || done_g !== 1'b0 || in_ready_g !== 1'b0) begin
                failures++;
                $display("FAIL deg%0d lane v=%b d=%h done=%b rdy=%b exp 1 %h 0 0",
                         r, lane_valid_g, lane_data_g, done_g, in_ready_g, val);
            end
            @(negedge clk);
            checks++;
            if (lane_valid_g !== 1'b0 || lane_data_g !== 8'h00 || done_g !== 1'b1 || busy_g !== 1'b1) begin
                failures++;
                $display("FAIL deg%0d done v=%b d=%h done=%b busy=%b exp 0 00 1 1",
                         r, lane_valid_g, lane_data_g, done_g, busy_g);
            end
            @(negedge clk);
            checks++;
            if (busy_g !== 1'b0 || done_g !== 1'b0) begin
                failures++;
                $display("FAIL deg%0d idle busy/done=%b%b exp 00", r, busy_g, done_g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tile(1'b0, 1'b0, 1'b0, "full");
        test_tile(1'b1, 1'b0, 1'b0, "bubble");
        test_tile(1'b0, 1'b0, 1'b1, "ignore");
        test_reset_mid_feed();
        test_back_to_back();
        test_tile(1'b0, 1'b1, 1'b0, "ones_e2e");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
